// File: rtl/m_data_mem.sv
// MEM-stage data memory: combinational sized/extended loads, byte/half/word
// stores committed at posedge via read-modify-write of one 32-bit word.
module m_data_mem #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        range_err
);

  localparam logic [2:0]  OP_W   = 3'b000;
  localparam logic [2:0]  OP_H   = 3'b001;
  localparam logic [2:0]  OP_HU  = 3'b010;
  localparam logic [2:0]  OP_B   = 3'b011;
  localparam logic [2:0]  OP_BU  = 3'b100;
  localparam logic [31:0] LP_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_cur;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic [31:0]      w_merged;
  logic             w_valid;

  assign w_idx = addr[IDX_W+1:2];
  assign w_cur = r_mem[w_idx];

  assign range_err = (addr >= LP_BYTES);

  always_comb begin
    align_err = 1'b0;
    case (op)
      OP_W:         align_err = (addr[1:0] != 2'b00);
      OP_H, OP_HU:  align_err = addr[0];
      default:      align_err = 1'b0;
    endcase
  end

  assign w_valid = !align_err && !range_err && (op <= OP_BU);

  assign w_half = addr[1] ? w_cur[31:16] : w_cur[15:0];

  always_comb begin
    w_byte = w_cur[7:0];
    case (addr[1:0])
      2'd0: w_byte = w_cur[7:0];
      2'd1: w_byte = w_cur[15:8];
      2'd2: w_byte = w_cur[23:16];
      2'd3: w_byte = w_cur[31:24];
      default: w_byte = w_cur[7:0];
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (w_valid) begin
      case (op)
        OP_W:    rdata = w_cur;
        OP_H:    rdata = {{16{w_half[15]}}, w_half};
        OP_HU:   rdata = {16'h0, w_half};
        OP_B:    rdata = {{24{w_byte[7]}}, w_byte};
        OP_BU:   rdata = {24'h0, w_byte};
        default: rdata = 32'h0;
      endcase
    end
  end

  // Only the addressed lane changes; the rest of the word is carried over.
  always_comb begin
    w_merged = w_cur;
    case (op)
      OP_W: w_merged = wdata;
      OP_H, OP_HU: begin
        if (addr[1]) w_merged[31:16] = wdata[15:0];
        else         w_merged[15:0]  = wdata[15:0];
      end
      OP_B, OP_BU: begin
        case (addr[1:0])
          2'd0: w_merged[7:0]   = wdata[7:0];
          2'd1: w_merged[15:8]  = wdata[7:0];
          2'd2: w_merged[23:16] = wdata[7:0];
          2'd3: w_merged[31:24] = wdata[7:0];
          default: w_merged = w_cur;
        endcase
      end
      default: w_merged = w_cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (we && w_valid) begin
      r_mem[w_idx] <= w_merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && we && w_valid)
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
  end
`endif

endmodule
